seven_segment_scan_driver: RTL

- Consumes the 12-bit packed BCD value (hundreds[11:8], tens[7:4], units[3:0]) produced by the binary-to-BCD converter.
- Drives a 4-digit, common-anode, multiplexed seven-segment display by time-division scanning.
- Double-buffers the input so a displayed frame never mixes old and new digits.
- Applies optional leading-zero blanking and anti-ghosting guard time.

---
 rtl/seven_segment_scan_driver_pkg.sv | 21 ++
 rtl/seven_segment_scan_driver_decode.sv | 32 +++
 rtl/seven_segment_scan_driver.sv | 114 +++++++++++
 3 files changed

// File: rtl/seven_segment_scan_driver_pkg.sv
// Shared constants for the multiplexed seven-segment display path.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seven_segment_scan_driver_pkg;

  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] IDX_LAST = 2'd3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seven_segment_scan_driver_decode.sv
// Combinational BCD nibble to active-low segment pattern.
// Non-decimal nibbles render as a dash so bad input is visible on the display.
module bcd_to_seven_segment
  import seven_segment_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-division scan driver for a 4-digit common-anode display showing a
// double-buffered 3-digit BCD value with optional leading-zero blanking.
module seven_segment_scan_driver
  import seven_segment_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] BCD_code,
  input  logic        load,
  input  logic        lz_blank_en,
  output logic [3:0]  anode_n,
  output logic [6:0]  seg_n,
  output logic        frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

  logic [CNT_W-1:0] slot_cnt;
  logic [IDX_W-1:0] idx;
  logic [11:0]      pending;
  logic [11:0]      display;
  logic             pending_valid;

  logic             tc;
  logic             boundary;
  logic             in_guard;
  logic             digit_blank;
  logic [3:0]       nib;
  logic [6:0]       dec_seg;

  assign tc       = (slot_cnt == CNT_TC);
  assign boundary = tc && (idx == IDX_LAST);
  assign in_guard = (slot_cnt < GUARD_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (tc) begin
      slot_cnt <= '0;
      idx      <= idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // load is a one-cycle strobe with no ready: BCD_code is taken whenever
  // load is high. The display register only changes at a frame boundary, and
  // a load landing exactly on the boundary bypasses pending so it shows now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending       <= 12'h000;
      display       <= 12'h000;
      pending_valid <= 1'b0;
    end else begin
      if (load) begin
        pending <= BCD_code;
      end
      if (boundary) begin
        pending_valid <= 1'b0;
        if (load) begin
          display <= BCD_code;
        end else if (pending_valid) begin
          display <= pending;
        end
      end else if (load) begin
        pending_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    nib         = 4'd0;
    digit_blank = 1'b0;
    case (idx)
      2'd0: nib = display[3:0];
      2'd1: begin
        nib         = display[7:4];
        digit_blank = lz_blank_en && (display[11:4] == 8'h00);
      end
      2'd2: begin
        nib         = display[11:8];
        digit_blank = lz_blank_en && (display[11:8] == 4'h0);
      end
      default: digit_blank = 1'b1;
    endcase
  end

  bcd_to_seven_segment u_decode (
    .nibble (nib),
    .blank  (digit_blank),
    .seg    (dec_seg)
  );

  // Segments are also blanked during the guard so nothing lingers on the bus
  // while the anodes switch over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_n    <= 4'b1111;
      seg_n      <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      anode_n    <= (in_guard || digit_blank) ? 4'b1111 : ~(4'b0001 << idx);
      seg_n      <= in_guard ? SEG_BLANK : dec_seg;
      frame_done <= boundary;
    end
  end

endmodule
